// File: rtl/turn_signal_request_gen_if.sv
// turn_signal_request_gen_if: raw buttons and ack in, active-low request levels out
interface turn_signal_request_gen_if;
  logic btn_left_n;
  logic btn_right_n;
  logic btn_haz_n;
  logic ack;
  logic left;
  logic right;
  logic haz;
  logic pending;
  modport master (
    input  btn_left_n, btn_right_n, btn_haz_n, ack,
    output left, right, haz, pending
  );
  modport slave (
    output btn_left_n, btn_right_n, btn_haz_n, ack,
    input  left, right, haz, pending
  );
endinterface

// File: rtl/turn_signal_request_gen.sv
// turn_signal_request_gen: sync/debounce/edge-detect three buttons into one latched request; HOLD_REPEAT_EN adds hold-repeat
module turn_signal_request_gen #(
  parameter int DB_CYCLES     = 1000000,
  parameter int REPEAT_CYCLES = 25000000
) (
  input logic                        clk,
  input logic                        reset,
  turn_signal_request_gen_if.master  bus
);
  localparam int CW = $clog2(DB_CYCLES + 1);
  typedef enum logic [1:0] {NONE, LEFT, RIGHT, HAZ} req_t;
  // Button vectors are ordered {haz, right, left}
  logic [2:0]    w_raw;
  logic [2:0]    r_sync1;
  logic [2:0]    r_sync2;
  logic [2:0]    r_db;
  logic [2:0]    r_db_q;
  logic [2:0]    r_press;
  logic [2:0]    w_fall;
  logic [2:0]    w_rep;
  logic [2:0]    w_evt;
  logic [CW-1:0] r_cnt [3];
  req_t          r_state;
  req_t          w_next;
  logic          r_left;
  logic          r_right;
  logic          r_haz;
  logic          r_pending;
  if (DB_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_bad_param
    $error("DB_CYCLES and REPEAT_CYCLES must be at least 1");
  end
  assign w_raw = {bus.btn_haz_n, bus.btn_right_n, bus.btn_left_n};
  // Two-stage synchronizer for the asynchronous button pins
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
    end
  end
  // Debounce: accept a new level only after DB_CYCLES consecutive mismatching cycles
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_db   <= '1;
      r_db_q <= '1;
      for (int i = 0; i < 3; i++) r_cnt[i] <= '0;
    end else begin
      r_db_q <= r_db;
      for (int i = 0; i < 3; i++)
        if (r_sync2[i] == r_db[i]) r_cnt[i] <= '0;
        else if (r_cnt[i] == CW'(DB_CYCLES - 1)) begin
          r_db[i]  <= r_sync2[i];
          r_cnt[i] <= '0;
        end else r_cnt[i] <= r_cnt[i] + 1'b1;
    end
  end
  assign w_fall = r_db_q & ~r_db;
  // Register the debounced falling edge as a one-cycle press pulse
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_press <= '0;
    else        r_press <= w_fall;
  end
`ifdef HOLD_REPEAT_EN
  localparam int RW = $clog2(REPEAT_CYCLES + 1);
  logic [RW-1:0] r_rcnt [3];
  logic [2:0]    r_rep;
  // While a button stays debounced-low, emit an extra press every REPEAT_CYCLES cycles
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rep <= '0;
      for (int i = 0; i < 3; i++) r_rcnt[i] <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        r_rep[i] <= 1'b0;
        if (r_db[i]) r_rcnt[i] <= '0;
        else if (r_rcnt[i] == RW'(REPEAT_CYCLES - 1)) begin
          r_rcnt[i] <= '0;
          r_rep[i]  <= 1'b1;
        end else r_rcnt[i] <= r_rcnt[i] + 1'b1;
      end
    end
  end
  assign w_rep = r_rep;
`else
  assign w_rep = '0;
`endif
  assign w_evt = r_press | w_rep;
  // Request state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= NONE;
    else        r_state <= w_next;
  end
  // Next request: haz beats left beats right when idle; haz upgrades and survives a same-cycle ack
  always_comb begin
    w_next = r_state;
    if (r_state == NONE) w_next = w_evt[2] ? HAZ : w_evt[0] ? LEFT : w_evt[1] ? RIGHT : NONE;
    else                 w_next = w_evt[2] ? HAZ : bus.ack ? NONE : r_state;
  end
  // Active-low request outputs registered from the next state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_left    <= 1'b1;
      r_right   <= 1'b1;
      r_haz     <= 1'b1;
      r_pending <= 1'b0;
    end else begin
      r_left    <= w_next != LEFT;
      r_right   <= w_next != RIGHT;
      r_haz     <= w_next != HAZ;
      r_pending <= w_next != NONE;
    end
  end
  assign bus.left    = r_left;
  assign bus.right   = r_right;
  assign bus.haz     = r_haz;
  assign bus.pending = r_pending;
endmodule

// File: tb/tb_turn_signal_request_gen.sv
// tb_turn_signal_request_gen: directed checks of debounce latency, priority, ack and reset; observed as {left,right,haz,pending}
module tb_turn_signal_request_gen;
  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;
  int   n_req;
  logic [3:0] w_obs;
  turn_signal_request_gen_if bus();
  turn_signal_request_gen #(.DB_CYCLES(4), .REPEAT_CYCLES(10)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );
  assign w_obs = {bus.left, bus.right, bus.haz, bus.pending};
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%b exp=%b", tag, got, exp);
    end
  endtask
  task automatic ack_pulse();
    bus.ack = 1'b1;
    step(1);
    bus.ack = 1'b0;
  endtask
  task automatic release_all();
    bus.btn_left_n  = 1'b1;
    bus.btn_right_n = 1'b1;
    bus.btn_haz_n   = 1'b1;
    step(10);
  endtask
  initial begin
    n_tests = 0;
    n_fail  = 0;
    n_req   = 0;
    reset           = 1'b0;
    bus.btn_left_n  = 1'b1;
    bus.btn_right_n = 1'b1;
    bus.btn_haz_n   = 1'b1;
    bus.ack         = 1'b0;
    step(3);
    check("reset_idle", w_obs, 4'b1110);
    step(20);
    check("reset_hold", w_obs, 4'b1110);
    reset = 1'b1;
    step(5);
    check("idle", w_obs, 4'b1110);
    bus.btn_left_n = 1'b0;
    step(7);
    check("left_latency_pre", w_obs, 4'b1110);
    step(1);
    check("left_latency", w_obs, 4'b0111);
    ack_pulse();
    check("left_ack", w_obs, 4'b1110);
`ifndef HOLD_REPEAT_EN
    step(15);
    check("left_hold_no_rereq", w_obs, 4'b1110);
`endif
    release_all();
    check("left_release", w_obs, 4'b1110);
    for (int g = 0; g < 5; g++) begin
      bus.btn_right_n = 1'b0;
      for (int c = 0; c < 3; c++) begin
        step(1);
        check("glitch_low", w_obs, 4'b1110);
      end
      bus.btn_right_n = 1'b1;
      for (int c = 0; c < 3; c++) begin
        step(1);
        check("glitch_high", w_obs, 4'b1110);
      end
    end
    step(10);
    check("glitch_settle", w_obs, 4'b1110);
    bus.btn_left_n = 1'b0;
    bus.btn_haz_n  = 1'b0;
    step(8);
    check("simul_haz_wins", w_obs, 4'b1101);
    ack_pulse();
    check("simul_ack", w_obs, 4'b1110);
    release_all();
    bus.btn_left_n = 1'b0;
    step(8);
    check("upg_left", w_obs, 4'b0111);
    bus.btn_haz_n = 1'b0;
    step(8);
    check("upg_haz", w_obs, 4'b1101);
    ack_pulse();
    release_all();
    check("upg_clear", w_obs, 4'b1110);
    bus.btn_haz_n = 1'b0;
    step(8);
    check("haz_pending", w_obs, 4'b1101);
    bus.btn_right_n = 1'b0;
    step(10);
    check("haz_ignores_right", w_obs, 4'b1101);
    ack_pulse();
    check("haz_ack", w_obs, 4'b1110);
    release_all();
    bus.btn_right_n = 1'b0;
    step(8);
    check("right_req", w_obs, 4'b1011);
    bus.btn_left_n = 1'b0;
    step(10);
    check("right_ignores_left", w_obs, 4'b1011);
    ack_pulse();
    release_all();
    check("right_clear", w_obs, 4'b1110);
    bus.btn_left_n = 1'b0;
    step(8);
    check("ackhaz_left", w_obs, 4'b0111);
    bus.btn_haz_n = 1'b0;
    step(7);
    check("ackhaz_pre", w_obs, 4'b0111);
    ack_pulse();
    check("ackhaz_haz_kept", w_obs, 4'b1101);
    ack_pulse();
    release_all();
    check("ackhaz_clear", w_obs, 4'b1110);
    bus.btn_left_n = 1'b0;
    step(8);
    check("rst_left", w_obs, 4'b0111);
    reset = 1'b0;
    #1;
    check("rst_async", w_obs, 4'b1110);
    step(3);
    check("rst_hold", w_obs, 4'b1110);
    reset = 1'b1;
    step(7);
    check("rst_repress_pre", w_obs, 4'b1110);
    step(1);
    check("rst_repress", w_obs, 4'b0111);
    ack_pulse();
    release_all();
    check("rst_clear", w_obs, 4'b1110);
    bus.btn_left_n = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step(1);
      if (!bus.left && !bus.ack) begin
        n_req++;
        bus.ack = 1'b1;
      end else bus.ack = 1'b0;
    end
    bus.ack = 1'b0;
`ifdef HOLD_REPEAT_EN
    check("repeat_count", 4'(n_req), 4'd4);
`else
    check("repeat_count", 4'(n_req), 4'd1);
`endif
    release_all();
    check("final_idle", w_obs, 4'b1110);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
